ibus_responder: RTL and testbench



---
 rtl/ibus_responder.sv | 120 ++++++++++++
 tb/tb_ibus_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ibus_responder.sv
// Instruction-bus memory model: accepts a fetch request and returns one word LATENCY cycles later.
// One transaction in flight at a time; requests are ignored while BUSY or RESP (throughput 1 per LATENCY+1).
module ibus_responder #(
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2,
  parameter logic [63:0] BASE    = 64'h8000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_ireq_valid,
  input  logic [63:0]              i_ireq_addr,
  output logic                     o_iresp_addr_ok,
  output logic                     o_iresp_data_ok,
  output logic [31:0]              o_iresp_data,
  output logic                     o_resp_err,
  input  logic                     i_load_en,
  input  logic [$clog2(DEPTH)-1:0] i_load_idx,
  input  logic [31:0]              i_load_data
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [63:0] r_areg;
  logic [31:0] r_dreg;
  logic        r_ereg;
  logic        w_accept;
  logic        w_capture;
  logic        w_resp;

  logic [31:0] r_mem [DEPTH];

  logic [63:0] w_dec_addr;
  logic [61:0] w_off_w;
  logic [AW-1:0] w_idx;
  logic        w_err;
  logic [31:0] w_rd;

  // With LATENCY==1 the capture happens on the acceptance edge, so decode the live address.
  assign w_dec_addr = (r_state == IDLE) ? i_ireq_addr : r_areg;
  assign w_off_w    = 62'((w_dec_addr - BASE) >> 2);
  assign w_idx      = w_off_w[AW-1:0];
  assign w_err      = (w_dec_addr < BASE) | (w_dec_addr[1:0] != 2'b00) | (w_off_w >= 62'(DEPTH));
  assign w_rd       = r_mem[w_idx];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_ireq_valid) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_state_nxt = RESP;
            w_capture   = 1'b1;
          end else begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = RESP;
          w_capture   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_areg  <= 64'd0;
      r_dreg  <= 32'd0;
      r_ereg  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_areg <= i_ireq_addr;
      end
      if (w_capture) begin
        r_dreg <= w_err ? 32'd0 : w_rd;
        r_ereg <= w_err;
      end
    end
  end

  // Store is deliberately outside reset so a preload survives it; a same-edge write is not seen by the capture.
  always_ff @(posedge clk) begin
    if (i_load_en) begin
      r_mem[i_load_idx] <= i_load_data;
    end
  end

  assign w_resp          = (r_state == RESP);
  assign o_iresp_addr_ok = w_resp;
  assign o_iresp_data_ok = w_resp;
  assign o_iresp_data    = w_resp ? r_dreg : 32'd0;
  assign o_resp_err      = w_resp ? r_ereg : 1'b0;

endmodule

// File: tb/tb_ibus_responder.sv
// Directed bench for ibus_responder: three instances at LATENCY 1, 2 and 3 share clock, reset and load port.
module tb_ibus_responder;

  localparam int          DEPTH = 1024;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        vld  [3];
  logic [63:0] addr [3];
  logic        aok  [3];
  logic        dok  [3];
  logic [31:0] dat  [3];
  logic        err  [3];
  logic        load_en;
  logic [9:0]  load_idx;
  logic [31:0] load_data;

  logic [31:0] exp_mem [DEPTH];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ibus_responder #(.DEPTH(DEPTH), .LATENCY(1), .BASE(BASE)) u1 (
    .clk(clk), .reset(reset),
    .i_ireq_valid(vld[0]), .i_ireq_addr(addr[0]),
    .o_iresp_addr_ok(aok[0]), .o_iresp_data_ok(dok[0]), .o_iresp_data(dat[0]), .o_resp_err(err[0]),
    .i_load_en(load_en), .i_load_idx(load_idx), .i_load_data(load_data)
  );

  ibus_responder #(.DEPTH(DEPTH), .LATENCY(2), .BASE(BASE)) u2 (
    .clk(clk), .reset(reset),
    .i_ireq_valid(vld[1]), .i_ireq_addr(addr[1]),
    .o_iresp_addr_ok(aok[1]), .o_iresp_data_ok(dok[1]), .o_iresp_data(dat[1]), .o_resp_err(err[1]),
    .i_load_en(load_en), .i_load_idx(load_idx), .i_load_data(load_data)
  );

  ibus_responder #(.DEPTH(DEPTH), .LATENCY(3), .BASE(BASE)) u3 (
    .clk(clk), .reset(reset),
    .i_ireq_valid(vld[2]), .i_ireq_addr(addr[2]),
    .o_iresp_addr_ok(aok[2]), .o_iresp_data_ok(dok[2]), .o_iresp_data(dat[2]), .o_resp_err(err[2]),
    .i_load_en(load_en), .i_load_idx(load_idx), .i_load_data(load_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    load_en   = 1'b1;
    load_idx  = 10'(idx);
    load_data = d;
    exp_mem[idx] = d;
    tick();
    load_en = 1'b0;
  endtask

  // Single fetch starting from an IDLE cycle; checks silence before and after the one pulse.
  task automatic fetch(input int k, input int lat, input logic [63:0] a,
                       input logic [31:0] ed, input logic ee, input string tag);
    vld[k]  = 1'b1;
    addr[k] = a;
    for (int c = 0; c < lat; c++) begin
      chk({tag, "_pre"}, 64'(dok[k]), 64'd0);
      tick();
    end
    chk({tag, "_dok"},  64'(dok[k]), 64'd1);
    chk({tag, "_aok"},  64'(aok[k]), 64'd1);
    chk({tag, "_data"}, 64'(dat[k]), 64'(ed));
    chk({tag, "_err"},  64'(err[k]), 64'(ee));
    vld[k] = 1'b0;
    tick();
    chk({tag, "_post"},  64'(dok[k]), 64'd0);
    chk({tag, "_pdata"}, 64'(dat[k]), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    load_en   = 1'b0;
    load_idx  = '0;
    load_data = '0;
    for (int k = 0; k < 3; k++) begin
      vld[k]  = 1'b1;
      addr[k] = BASE;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_aok%0d", k),  64'(aok[k]), 64'd0);
      chk($sformatf("rst_dok%0d", k),  64'(dok[k]), 64'd0);
      chk($sformatf("rst_data%0d", k), 64'(dat[k]), 64'd0);
      chk($sformatf("rst_err%0d", k),  64'(err[k]), 64'd0);
      vld[k] = 1'b0;
    end

    // Preload while in reset: writes are accepted in any state.
    load(0, 32'h0000_0013);
    load(1, 32'h0010_0093);
    for (int i = 2; i < 64; i++) load(i, 32'h1357_0000 + 32'(i) * 32'h0101_0101);
    load(DEPTH - 1, 32'hCAFE_F00D);
    for (int k = 0; k < 3; k++) chk($sformatf("rst_hold_dok%0d", k), 64'(dok[k]), 64'd0);
    reset = 1'b0;
    tick();

    // LATENCY=2: valid held through the pulse, next address presented the cycle after data_ok.
    vld[1]  = 1'b1;
    addr[1] = BASE;
    chk("l2_c0", 64'(dok[1]), 64'd0);
    tick();
    chk("l2_c1", 64'(dok[1]), 64'd0);
    tick();
    chk("l2_c2_dok",  64'(dok[1]), 64'd1);
    chk("l2_c2_aok",  64'(aok[1]), 64'd1);
    chk("l2_c2_data", 64'(dat[1]), 64'h0000_0013);
    chk("l2_c2_err",  64'(err[1]), 64'd0);
    addr[1] = BASE + 64'd4;
    tick();
    chk("l2_c3", 64'(dok[1]), 64'd0);
    tick();
    chk("l2_c4", 64'(dok[1]), 64'd0);
    tick();
    chk("l2_c5_dok",  64'(dok[1]), 64'd1);
    chk("l2_c5_data", 64'(dat[1]), 64'h0010_0093);
    chk("l2_c5_err",  64'(err[1]), 64'd0);
    vld[1] = 1'b0;
    tick();
    chk("l2_c6", 64'(dok[1]), 64'd0);

    // Address decode boundaries.
    fetch(1, 2, 64'h8000_0002, 32'h0, 1'b1, "err_misal2");
    fetch(1, 2, 64'h7FFF_FFFC, 32'h0, 1'b1, "err_below");
    fetch(1, 2, BASE + 64'(4 * DEPTH), 32'h0, 1'b1, "err_top");
    fetch(1, 2, BASE + 64'(4 * (DEPTH - 1)), 32'hCAFE_F00D, 1'b0, "last_word");
    fetch(2, 3, 64'h8000_0001, 32'h0, 1'b1, "err_misal1");
    fetch(2, 3, BASE + 64'd4, 32'h0010_0093, 1'b0, "l3_word1");
    fetch(0, 1, 64'hFFFF_FFFF_8000_0000, 32'h0, 1'b1, "err_wrap");

    // LATENCY=3: reset in the BUSY cycle aborts, request during reset ignored, then completes.
    vld[2]  = 1'b1;
    addr[2] = BASE + 64'd8;
    chk("rb_c0", 64'(dok[2]), 64'd0);
    tick();
    reset = 1'b1;
    chk("rb_c1", 64'(dok[2]), 64'd0);
    tick();
    chk("rb_c2", 64'(dok[2]), 64'd0);
    tick();
    chk("rb_c3", 64'(dok[2]), 64'd0);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rb_wait%0d", c), 64'(dok[2]), 64'd0);
      tick();
    end
    chk("rb_dok",  64'(dok[2]), 64'd1);
    chk("rb_data", 64'(dat[2]), 64'(exp_mem[2]));
    chk("rb_err",  64'(err[2]), 64'd0);
    vld[2] = 1'b0;
    tick();
    chk("rb_post", 64'(dok[2]), 64'd0);

    // Write to index 0 on the capture edge returns the old word.
    vld[1]  = 1'b1;
    addr[1] = BASE;
    chk("rw_c0", 64'(dok[1]), 64'd0);
    tick();
    load_en   = 1'b1;
    load_idx  = 10'd0;
    load_data = 32'hDEAD_BEEF;
    tick();
    load_en = 1'b0;
    chk("rw_dok",  64'(dok[1]), 64'd1);
    chk("rw_old",  64'(dat[1]), 64'h0000_0013);
    exp_mem[0] = 32'hDEAD_BEEF;
    vld[1] = 1'b0;
    tick();
    chk("rw_post", 64'(dok[1]), 64'd0);
    fetch(1, 2, BASE, 32'hDEAD_BEEF, 1'b0, "rw_new");

    // LATENCY=1 sweep, valid held continuously, address advanced on data_ok.
    vld[0] = 1'b1;
    for (int i = 0; i < 64; i++) begin
      addr[0] = BASE + 64'(4 * i);
      chk($sformatf("sw_idle%0d", i), 64'(dok[0]), 64'd0);
      tick();
      chk($sformatf("sw_dok%0d", i),  64'(dok[0]), 64'd1);
      chk($sformatf("sw_data%0d", i), 64'(dat[0]), 64'(exp_mem[i]));
      chk($sformatf("sw_err%0d", i),  64'(err[0]), 64'd0);
      if (i == 63) vld[0] = 1'b0;
      tick();
    end
    chk("sw_end0", 64'(dok[0]), 64'd0);
    tick();
    chk("sw_end1", 64'(dok[0]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
